// File: rtl/logic_chunk_sequencer.sv
// logic_chunk_sequencer
//   Multi-cycle controller that applies a W-bit bitwise operation (NOT/AND/OR/XOR)
//   through an N-bit slice, one chunk per clock, low chunk first.
//   Handshake: start (accepted in IDLE only) -> busy through RUN and DONE,
//   done pulses for one cycle. result is held until the next accepted start.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset
//   start   in   request, accepted only in IDLE
//   op      in   2'b00 NOT a, 2'b01 a AND b, 2'b10 a OR b, 2'b11 a XOR b
//   a, b    in   W-bit operands, sampled on accepted start
//   busy    out  high in RUN and DONE
//   done    out  one-cycle pulse in DONE
//   result  out  registered W-bit result
//   zero    out  (LOGIC_SEQ_FLAGS_EN only) result == 0, updated on final chunk
//   parity  out  (LOGIC_SEQ_FLAGS_EN only) XOR-reduction of result, updated on final chunk
//
// Optional feature macro: LOGIC_SEQ_FLAGS_EN

module logic_chunk_sequencer #(
    parameter int unsigned W = 16,
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
`ifdef LOGIC_SEQ_FLAGS_EN
    output logic         zero,
    output logic         parity,
`endif
    output logic [W-1:0] result
);

    localparam int unsigned Chunks = W / N;
    // Keep the index at least one bit wide so W == N still elaborates.
    localparam int unsigned IdxW   = (Chunks > 1) ? $clog2(Chunks) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(Chunks - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    result_q, result_d;
    logic [N-1:0]    a_chunk, b_chunk, res_chunk;
    logic            last_chunk;

    // Bitwise slice: the only datapath, shared across all chunks.
    always_comb begin
        a_chunk = a_q[idx_q*N +: N];
        b_chunk = b_q[idx_q*N +: N];
        unique case (op_q)
            2'b00:   res_chunk = ~a_chunk;
            2'b01:   res_chunk = a_chunk & b_chunk;
            2'b10:   res_chunk = a_chunk | b_chunk;
            default: res_chunk = a_chunk ^ b_chunk;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        result_d   = result_q;
        last_chunk = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    op_d     = op;
                    result_d = '0;
                    idx_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                result_d[idx_q*N +: N] = res_chunk;
                if (idx_q == LastIdx) begin
                    last_chunk = 1'b1;
                    state_d    = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == StRun) || (state_q == StDone);
    assign done   = (state_q == StDone);
    assign result = result_q;

`ifdef LOGIC_SEQ_FLAGS_EN
    logic zero_q, zero_d;
    logic parity_q, parity_d;

    // Flags are computed over the complete next-state result, so they see the
    // final chunk in the same edge that writes it.
    always_comb begin
        zero_d   = zero_q;
        parity_d = parity_q;
        if (last_chunk) begin
            zero_d   = ~|result_d;
            parity_d = ^result_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign zero   = zero_q;
    assign parity = parity_q;
`else
    logic unused_last_chunk;
    assign unused_last_chunk = last_chunk;
`endif

endmodule

// File: tb/tb_logic_chunk_sequencer.sv
// Self-checking bench for logic_chunk_sequencer (W=16, N=4).
// Expected values come from a whole-word reference model: the full result is
// the plain bitwise operation on the operands, and after k chunk edges the
// visible result is that value masked to its low k*N bits.

module tb_logic_chunk_sequencer;

    localparam int unsigned W = 16;
    localparam int unsigned N = 4;
    localparam int unsigned C = W / N;

    logic         clk;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
`ifdef LOGIC_SEQ_FLAGS_EN
    logic         zero;
    logic         parity;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Flag model state: what zero/parity should currently hold.
    logic exp_zero   = 1'b0;
    logic exp_parity = 1'b0;

    logic_chunk_sequencer #(
        .W(W),
        .N(N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
`ifdef LOGIC_SEQ_FLAGS_EN
        .zero  (zero),
        .parity(parity),
`endif
        .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] av,
                                           input logic [W-1:0] bv);
        case (o)
            2'b00:   return ~av;
            2'b01:   return av & bv;
            2'b10:   return av | bv;
            default: return av ^ bv;
        endcase
    endfunction

    function automatic logic [W-1:0] low_mask(input int bits);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < W; i++) begin
            if (i < bits) m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag);
`ifdef LOGIC_SEQ_FLAGS_EN
        check({tag, "_zero"}, W'(zero), W'(exp_zero));
        check({tag, "_parity"}, W'(parity), W'(exp_parity));
`else
        tests_run = tests_run + 0;
`endif
    endtask

    // Issue one operation from IDLE and follow it to the first IDLE cycle after DONE.
    // With poke set, start is forced high with a=FFFF during RUN cycle 2.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input bit poke);
        logic [W-1:0] exp;
        exp   = model(o, av, bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        check({tag, "_acc_busy"}, W'(busy), W'(1));
        check({tag, "_acc_done"}, W'(done), W'(0));
        check({tag, "_acc_res"}, result, '0);
        check_flags({tag, "_acc"});
        for (int k = 1; k <= C; k++) begin
            // Garbage on inputs during RUN must not disturb the operation.
            start = (poke && k == 2) ? 1'b1 : 1'($urandom_range(0, 1));
            op    = 2'($urandom);
            a     = (poke && k == 2) ? 16'hFFFF : W'($urandom);
            b     = W'($urandom);
            tick();
            check($sformatf("%s_res%0d", tag, k), result, exp & low_mask(k * N));
            check($sformatf("%s_busy%0d", tag, k), W'(busy), W'(1));
            check($sformatf("%s_done%0d", tag, k), W'(done), W'(k == C));
        end
        exp_zero   = (exp == '0);
        exp_parity = ^exp;
        check_flags({tag, "_done"});
        start = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        check({tag, "_idle_busy"}, W'(busy), W'(0));
        check({tag, "_idle_done"}, W'(done), W'(0));
        check({tag, "_idle_res"}, result, exp);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_res", result, '0);
        check_flags("rst");
        reset = 1'b0;
        tick();
        check("rst_idle_busy", W'(busy), W'(0));

        // NOT with full chunk progression, then a hold cycle.
        run_op("not", 2'b00, 16'h00FF, 16'h0000, 1'b0);
        check("not_val", result, 16'hFF00);
        tick();
        check("not_hold", result, 16'hFF00);

        // AND then OR issued back-to-back in the first IDLE cycle.
        run_op("and", 2'b01, 16'hF0F0, 16'hFF00, 1'b0);
        check("and_val", result, 16'hF000);
        run_op("or", 2'b10, 16'hF0F0, 16'hFF00, 1'b0);
        check("or_val", result, 16'hFFF0);

        // Flag cases (flags checked only when the feature is built in).
        run_op("xor", 2'b11, 16'hAAAA, 16'h5555, 1'b0);
        check("xor_val", result, 16'hFFFF);
        run_op("andz", 2'b01, 16'h0F0F, 16'hF0F0, 1'b0);
        check("andz_val", result, 16'h0000);

        // Start pulse in RUN cycle 2 is ignored; no second operation follows.
        run_op("ign", 2'b00, 16'h1234, 16'h0000, 1'b1);
        check("ign_val", result, 16'hEDCB);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("ign_nobusy%0d", i), W'(busy), W'(0));
            check($sformatf("ign_nodone%0d", i), W'(done), W'(0));
        end

        // Reset in RUN cycle 2 abandons the operation.
        start = 1'b1;
        op    = 2'b11;
        a     = 16'hFFFF;
        b     = 16'h0000;
        tick();
        start = 1'b0;
        tick();
        check("mid_run_res", result, 16'h000F);
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        exp_zero   = 1'b0;
        exp_parity = 1'b0;
        check("mid_busy", W'(busy), W'(0));
        check("mid_done", W'(done), W'(0));
        check("mid_res", result, '0);
        check_flags("mid");
        for (int i = 0; i < C + 2; i++) begin
            tick();
            check($sformatf("mid_nodone%0d", i), W'(done), W'(0));
            check($sformatf("mid_nobusy%0d", i), W'(busy), W'(0));
        end
        run_op("fresh", 2'b00, 16'h0000, 16'h0000, 1'b0);
        check("fresh_val", result, 16'hFFFF);

        // Randomized operations, some back-to-back, some with idle gaps.
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("rnd%0d", i), 2'($urandom), W'($urandom), W'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/logic_chunk_sequencer.md
Name: logic_chunk_sequencer

Overview:
- Multi-cycle controller that runs a W-bit bitwise logic operation (NOT/AND/OR/XOR) through an N-bit-wide bitwise slice, one chunk per clock.
- Sits between the CPU control unit and the narrow bitwise datapath, so one N-bit slice is time-shared across a wider operand.
- Uses a start/busy/done handshake. The result is held in a register until the next accepted start.

Parameters:
- W, 16, operand and result width in bits; must be an integer multiple of N.
- N, 4, chunk width processed per cycle (width of the bitwise slice).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only in IDLE
- op  input  2  operation: 00 NOT a, 01 a AND b, 10 a OR b, 11 a XOR b
- a  input  W  operand A; sampled on accepted start
- b  input  W  operand B; sampled on accepted start; ignored for NOT
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, high in DONE
- result  output  W  registered result

Behaviour:
- Reset
  - Sampled on a rising edge with reset=1.
  - Forces state=IDLE, chunk index=0, busy=0, done=0, result=0, and internal operand and op registers to 0.
  - Has priority over every other input, including when it arrives mid-operation: the in-flight operation is abandoned and no done is produced.
- State machine: IDLE, RUN, DONE.
- IDLE
  - busy=0, done=0.
  - On an edge with start=1: latch a, b and op; clear result to 0; set index=0; go to RUN.
- RUN
  - busy=1.
  - Each edge computes chunk idx from the latched operands and writes it into result[idx*N +: N].
  - Bits of result not yet written stay 0.
  - If idx==W/N-1, the edge writes the last chunk and goes to DONE; otherwise idx increments.
  - start is ignored.
- DONE
  - busy=1, done=1 for exactly one cycle; result holds the full W-bit value.
  - Next edge returns to IDLE unconditionally; start in DONE is ignored.
- Latency
  - With the start-accept edge as edge 0, the last chunk is written on edge W/N.
  - done is high in the cycle following edge W/N.
  - Back-to-back issue: a start presented in the first IDLE cycle after DONE is accepted.
- Held values
  - result keeps its final value through IDLE until the next accepted start clears it.
  - Changes on a/b/op after acceptance have no effect on the operation in progress.
- Arithmetic: purely bitwise per chunk, with no carries between chunks. Unused op encodings do not exist, since all 4 codes are defined.
- Degenerate case W==N: RUN lasts one cycle and done follows on the next cycle.

Optional Feature:
- Macro: LOGIC_SEQ_FLAGS_EN.
- Defined
  - Adds output zero (1 bit) and output parity (1 bit).
  - Both are registered and updated on the edge that writes the final chunk, computed over the complete W-bit result.
  - zero=1 iff the result is all zeros; parity = XOR-reduction of the result.
  - Both hold until the next final-chunk write, are cleared to 0 by reset, and are not cleared on start.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan (W=16, N=4):
- NOT: start=1, op=00, a=16'h00FF -> busy for 4 RUN cycles plus DONE. done pulses once in cycle 5 after accept with result=16'hFF00; busy=0 the next cycle and result still 16'hFF00.
- AND/OR: op=01, a=16'hF0F0, b=16'hFF00 -> result=16'hF000. Then back-to-back op=10 with the same operands -> result=16'hFFF0.
- XOR with flags (LOGIC_SEQ_FLAGS_EN): a=16'hAAAA, b=16'h5555 -> result=16'hFFFF, zero=0, parity=0. Then op=01, a=16'h0F0F, b=16'hF0F0 -> result=16'h0000, zero=1, parity=0.
- Ignored start: accept op=00, a=16'h1234; in RUN cycle 2 pulse start with a=16'hFFFF -> result=16'hEDCB, exactly one done pulse, no second operation.
- Mid-op reset: accept op=11, a=16'hFFFF, b=0; assert reset in RUN cycle 2 -> next cycle busy=0, done=0, result=0, and no done ever for that op. A fresh start with op=00, a=0 then gives result=16'hFFFF.
- Chunk progression: op=00, a=16'h0000; monitor result each RUN cycle -> 16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF.
